// File: rtl/eq2_bist_ctrl.sv
// BIST controller for a 2-bit equality comparator: replays 8 stored
// vectors, holds each for HOLD_CYCLES cycles and scores aeqb.
//
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   start              one-cycle pulse, begins a pass from IDLE
//   load_en/addr/data  vector memory write, {a[1:0], b[1:0], exp}
//   a, b               registered operands to the comparator
//   aeqb               comparator result
//   busy, done         pass in progress / one-cycle end-of-pass pulse
//   pass, err_cnt      last pass clean / mismatch count (sat. 15)
//   fail_addr          address of the first mismatching vector

module eq2_bist_ctrl #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       load_en,
    input  logic [2:0] load_addr,
    input  logic [4:0] load_data,
    output logic [1:0] a,
    output logic [1:0] b,
    input  logic       aeqb,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] fail_addr
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [3:0] DWELL_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state;
    logic [4:0] mem [8];
    logic [2:0] addr;
    logic [2:0] addr_nxt;
    logic [3:0] dwell;
    logic [4:0] first_vec;
    logic [4:0] cur_vec;
    logic [4:0] next_vec;
    logic       last_dwell;
    logic       mismatch;

    // A write to mem[0] in the start cycle must be seen by the first
    // vector, so bypass the array for that case.
    assign first_vec  = (load_en && load_addr == 3'd0) ? load_data
                                                       : mem[0];
    assign addr_nxt   = addr + 3'd1;
    assign cur_vec    = mem[addr];
    assign next_vec   = mem[addr_nxt];
    assign last_dwell = (dwell == DWELL_LAST);
    assign mismatch   = (aeqb != cur_vec[0]);

    // Vector memory: not reset, writable only outside a pass.
    always_ff @(posedge clk) begin
        if (load_en && !busy) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr      <= 3'd0;
            dwell     <= 4'd0;
            a         <= 2'd0;
            b         <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= 4'd0;
            fail_addr <= 3'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        addr      <= 3'd0;
                        dwell     <= 4'd0;
                        err_cnt   <= 4'd0;
                        fail_addr <= 3'd0;
                        pass      <= 1'b0;
                        a         <= first_vec[4:3];
                        b         <= first_vec[2:1];
                    end
                end
                RUN: begin
                    if (last_dwell) begin
                        if (mismatch) begin
                            if (err_cnt != 4'hF) begin
                                err_cnt <= err_cnt + 4'd1;
                            end
                            // err_cnt never returns to 0 in a pass, so
                            // zero means this is the first mismatch.
                            if (err_cnt == 4'd0) begin
                                fail_addr <= addr;
                            end
                        end
                        if (addr == 3'd7) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            a     <= 2'd0;
                            b     <= 2'd0;
                            pass  <= (err_cnt == 4'd0) && !mismatch;
                        end else begin
                            addr  <= addr_nxt;
                            dwell <= 4'd0;
                            a     <= next_vec[4:3];
                            b     <= next_vec[2:1];
                        end
                    end else begin
                        dwell <= dwell + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq2_bist_ctrl.sv
// Bench for eq2_bist_ctrl: two instances (HOLD_CYCLES 4 and 2) share
// stimulus; a vector-list model predicts operands, timing and scores.

module tb_eq2_bist_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       load_en;
    logic [2:0] load_addr;
    logic [4:0] load_data;
    logic       stuck;

    logic [1:0] a_o [2];
    logic [1:0] b_o [2];
    logic       aeqb_i [2];
    logic       busy_o [2];
    logic       done_o [2];
    logic       pass_o [2];
    logic [3:0] ec_o [2];
    logic [2:0] fa_o [2];

    logic [4:0] mem_m [8];
    logic [4:0] vbuf [8];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Comparator under test: a correct eq2, or stuck at 1.
    assign aeqb_i[0] = stuck | (a_o[0] == b_o[0]);
    assign aeqb_i[1] = stuck | (a_o[1] == b_o[1]);

    eq2_bist_ctrl #(.HOLD_CYCLES(4)) u_h4 (
        .clk(clk), .reset_n(reset_n), .start(start),
        .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .a(a_o[0]), .b(b_o[0]),
        .aeqb(aeqb_i[0]), .busy(busy_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .err_cnt(ec_o[0]), .fail_addr(fa_o[0])
    );

    eq2_bist_ctrl #(.HOLD_CYCLES(2)) u_h2 (
        .clk(clk), .reset_n(reset_n), .start(start),
        .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .a(a_o[1]), .b(b_o[1]),
        .aeqb(aeqb_i[1]), .busy(busy_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .err_cnt(ec_o[1]), .fail_addr(fa_o[1])
    );

    function automatic int hold_of(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Score of the first nv vectors against the chosen comparator.
    function automatic void model(input logic stk, input int nv,
                                  output int ec, output int fa);
        ec = 0;
        fa = 0;
        for (int i = 0; i < nv; i++) begin
            logic r;
            r = stk ? 1'b1 : (mem_m[i][4:3] == mem_m[i][2:1]);
            if (r != mem_m[i][0]) begin
                if (ec == 0) fa = i;
                ec++;
            end
        end
        if (ec > 15) ec = 15;
    endfunction

    task automatic load_word(input int ad, input logic [4:0] d);
        load_en   = 1'b1;
        load_addr = 3'(ad);
        load_data = d;
        mem_m[ad] = d;
        tick;
        load_en = 1'b0;
    endtask

    task automatic load_buf;
        for (int i = 0; i < 8; i++) load_word(i, vbuf[i]);
    endtask

    task automatic chk_quiet(input string nm);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s.u%0d.busy", nm, k), busy_o[k], 0);
            chk($sformatf("%s.u%0d.done", nm, k), done_o[k], 0);
            chk($sformatf("%s.u%0d.pass", nm, k), pass_o[k], 0);
            chk($sformatf("%s.u%0d.err", nm, k), ec_o[k], 0);
            chk($sformatf("%s.u%0d.fa", nm, k), fa_o[k], 0);
            chk($sformatf("%s.u%0d.a", nm, k), a_o[k], 0);
            chk($sformatf("%s.u%0d.b", nm, k), b_o[k], 0);
        end
    endtask

    // One full pass on both instances. load_c/start_c inject a write
    // or a start pulse in that RUN cycle; ld0 writes mem[0] together
    // with the start pulse.
    task automatic run_pass(input string nm, input logic stk,
                            input int load_c, input int start_c,
                            input logic ld0, input logic [4:0] ld0_v);
        int h, v, nv, ec, fa;
        stuck = stk;
        if (ld0) begin
            load_en   = 1'b1;
            load_addr = 3'd0;
            load_data = ld0_v;
            mem_m[0]  = ld0_v;
        end
        start = 1'b1;
        tick;
        start   = 1'b0;
        load_en = 1'b0;
        for (int j = 1; j <= 35; j++) begin
            if (j == load_c) begin
                load_en   = 1'b1;
                load_addr = 3'd2;
                load_data = 5'b11111;
            end
            if (j == start_c) start = 1'b1;
            for (int k = 0; k < 2; k++) begin
                h  = hold_of(k);
                nv = (j - 1) / h;
                if (nv > 8) nv = 8;
                model(stk, nv, ec, fa);
                chk($sformatf("%s.u%0d.c%0d.done", nm, k, j),
                    done_o[k], (j == 8 * h + 1) ? 1 : 0);
                chk($sformatf("%s.u%0d.c%0d.err", nm, k, j),
                    ec_o[k], ec);
                chk($sformatf("%s.u%0d.c%0d.fa", nm, k, j),
                    fa_o[k], fa);
                if (j <= 8 * h) begin
                    v = (j - 1) / h;
                    chk($sformatf("%s.u%0d.c%0d.busy", nm, k, j),
                        busy_o[k], 1);
                    chk($sformatf("%s.u%0d.c%0d.a", nm, k, j),
                        a_o[k], mem_m[v][4:3]);
                    chk($sformatf("%s.u%0d.c%0d.b", nm, k, j),
                        b_o[k], mem_m[v][2:1]);
                    chk($sformatf("%s.u%0d.c%0d.pass", nm, k, j),
                        pass_o[k], 0);
                end else begin
                    chk($sformatf("%s.u%0d.c%0d.busy", nm, k, j),
                        busy_o[k], 0);
                    chk($sformatf("%s.u%0d.c%0d.a", nm, k, j),
                        a_o[k], 0);
                    chk($sformatf("%s.u%0d.c%0d.b", nm, k, j),
                        b_o[k], 0);
                    chk($sformatf("%s.u%0d.c%0d.pass", nm, k, j),
                        pass_o[k], (ec == 0) ? 1 : 0);
                end
            end
            tick;
            load_en = 1'b0;
            start   = 1'b0;
        end
    endtask

    task automatic golden;
        vbuf[0] = 5'b00_00_1;
        vbuf[1] = 5'b01_00_0;
        vbuf[2] = 5'b01_11_0;
        vbuf[3] = 5'b10_10_1;
        vbuf[4] = 5'b11_11_1;
        vbuf[5] = 5'b00_11_0;
        vbuf[6] = 5'b10_01_0;
        vbuf[7] = 5'b01_01_1;
    endtask

    initial begin
        int ec, fa;
        logic [1:0] ra, rb;
        logic       eqb;
        reset_n   = 1'b0;
        start     = 1'b0;
        load_en   = 1'b0;
        load_addr = 3'd0;
        load_data = 5'd0;
        stuck     = 1'b0;
        repeat (3) tick;
        chk_quiet("reset");
        reset_n = 1'b1;
        tick;

        golden();
        load_buf();
        run_pass("good", 1'b0, 0, 0, 1'b0, 5'd0);
        run_pass("proto", 1'b0, 3, 5, 1'b0, 5'd0);

        load_word(3, 5'b10_10_0);
        run_pass("fault", 1'b0, 0, 0, 1'b0, 5'd0);
        load_word(3, 5'b10_10_1);
        run_pass("stuck", 1'b1, 0, 0, 1'b0, 5'd0);

        // Abort in cycle 10 of a stuck-comparator pass.
        stuck = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (9) tick;
        for (int k = 0; k < 2; k++) begin
            model(1'b1, 9 / hold_of(k), ec, fa);
            chk($sformatf("abort.pre.u%0d.err", k), ec_o[k], ec);
            chk($sformatf("abort.pre.u%0d.busy", k), busy_o[k], 1);
        end
        reset_n = 1'b0;
        repeat (2) tick;
        reset_n = 1'b1;
        chk_quiet("abort.rst");
        for (int c = 0; c < 5; c++) begin
            tick;
            chk($sformatf("abort.nodone0.c%0d", c), done_o[0], 0);
            chk($sformatf("abort.nodone1.c%0d", c), done_o[1], 0);
        end
        run_pass("after_abort", 1'b0, 0, 0, 1'b0, 5'd0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) begin
                ra = 2'($urandom_range(0, 3));
                rb = ($urandom_range(0, 1) == 1) ? ra
                                                 : 2'($urandom_range(0, 3));
                eqb = (ra == rb);
                if ($urandom_range(0, 3) == 0) eqb = ~eqb;
                vbuf[i] = {ra, rb, eqb};
            end
            load_buf();
            run_pass($sformatf("rnd%0d", r),
                     1'($urandom_range(0, 1)), 0, 0,
                     1'(r % 2), 5'($urandom_range(0, 31)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eq2_bist_ctrl.md
EQ2_BIST_CTRL -- requirements
Module: eq2_bist_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: clock cycles each vector is applied before the response is sampled; legal range 2..16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port start, input, 1: a one-cycle pulse that begins a test pass.
REQ-005 SHALL have port load_en, input, 1: write strobe for the vector memory.
REQ-006 SHALL have port load_addr, input, 3: vector memory write address.
REQ-007 SHALL have port load_data, input, 5: vector word, {a[1:0], b[1:0], expected aeqb}.
REQ-008 SHALL have port a, output, 2: registered operand driven to the comparator a input.
REQ-009 SHALL have port b, output, 2: registered operand driven to the comparator b input.
REQ-010 SHALL have port aeqb, input, 1: comparator result.
REQ-011 SHALL have port busy, output, 1: high while a pass is in progress.
REQ-012 SHALL have port done, output, 1: one-cycle pulse at the end of a pass.
REQ-013 SHALL have port pass, output, 1: high when the last completed pass had zero mismatches.
REQ-014 SHALL have port err_cnt, output, 4: mismatch count for the current or last pass.
REQ-015 SHALL have port fail_addr, output, 3: address of the first mismatching vector.

Function
REQ-016 SHALL hold an 8 x 5-bit vector memory; contents are not reset; load writes mem[load_addr] <= load_data at the clock edge when load_en=1 and busy=0.
REQ-017 SHALL ignore load_en while busy=1, leaving memory unchanged.
REQ-018 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-019 IDLE: a=b=0, busy=0; start=1 -> RUN at the next edge; at that edge addr=0, dwell=0, err_cnt=0, fail_addr=0, pass=0, and a/b are loaded from mem[0].
REQ-020 RUN: busy=1; dwell increments each cycle, and a/b stay stable for exactly HOLD_CYCLES cycles per vector.
REQ-021 RUN, at dwell=HOLD_CYCLES-1: aeqb is compared with mem[addr][0].
REQ-022 On a mismatch, err_cnt increments and saturates at 15.
REQ-023 On the first mismatch of a pass, fail_addr <= addr.
REQ-024 RUN, at dwell=HOLD_CYCLES-1 with addr<7: addr increments, dwell <= 0, and a/b are loaded from mem[addr+1] at the same edge.
REQ-025 RUN, at dwell=HOLD_CYCLES-1 with addr=7: next state is DONE, and pass <= (err_cnt==0 and no mismatch on vector 7).
REQ-026 DONE: lasts exactly one cycle with done=1, busy=0, a=b=0, then goes to IDLE.
REQ-027 start is ignored in RUN and in DONE; no restart mid-pass.
REQ-028 A pass lasts 8*HOLD_CYCLES cycles in RUN; done asserts in cycle 8*HOLD_CYCLES+1 after the start edge.
REQ-029 err_cnt, fail_addr and pass SHALL retain their values in IDLE until the next accepted start.
REQ-030 Loading and start in the same IDLE cycle: the write completes, and the pass reads the updated memory, including mem[0].

Reset
REQ-031 When reset_n=0 at a clock edge, the FSM goes to IDLE and a=b=0, busy=0, done=0, pass=0, err_cnt=0, fail_addr=0; addr and dwell are cleared.
REQ-032 Reset asserted mid-pass SHALL abort the pass with no done pulse; memory contents are preserved.
REQ-033 With no reset applied, the outputs are undefined; the bench SHALL apply reset_n=0 for at least 2 cycles before use.

Verification
REQ-034 Good run: load the 8 vectors {a,b,exp} = 00,00,1; 01,00,0; 01,11,0; 10,10,1; 11,11,1; 00,11,0; 10,01,0; 01,01,1 and pair with a correct eq2 model; start -> done at cycle 33 (HOLD_CYCLES=4), pass=1, err_cnt=0.
REQ-035 Single fault: as REQ-034 but mem[3] exp=0 -> pass=0, err_cnt=1, fail_addr=3.
REQ-036 Stuck comparator: aeqb tied to 1 -> err_cnt=4, fail_addr=1, pass=0.
REQ-037 Abort: reset_n=0 at cycle 10 of a pass -> busy=0, err_cnt=0, no done; a new start then gives pass=1 with the memory intact.
REQ-038 Protocol: load_en with load_addr=2, data 11111 while busy -> mem[2] unchanged; a start pulse mid-pass -> no restart, done still at cycle 33.
REQ-039 Timing check: a/b change only at dwell boundaries, each vector held for exactly HOLD_CYCLES cycles; repeat with HOLD_CYCLES=2 -> done at cycle 17.
